pellet_tracker: RTL

//  Downstream consumer of the ball/pac-man motion stage. Samples BallX/BallY each frame and

---
 rtl/pellet_tracker_if.sv | 27 ++
 rtl/pellet_tracker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pellet_tracker_if.sv
// Bus bundle between the pac-man motion stage / pellet-map ROM and pellet_tracker.
// The master modport is the environment side; the slave modport is the tracker side.
interface pellet_tracker_if #(
  parameter int unsigned GRID_COLS = 28
);
  logic                 start;
  logic [9:0]           BallX;
  logic [9:0]           BallY;
  logic [5:0]           map_addr;
  logic [GRID_COLS-1:0] map_data;
  logic [15:0]          score;
  logic [9:0]           pellets_left;
  logic                 eat_pulse;
  logic                 level_clear;
  logic                 freeze;
  logic                 power_active;

  modport master (
    output start, BallX, BallY, map_data,
    input  map_addr, score, pellets_left, eat_pulse, level_clear, freeze, power_active
  );

  modport slave (
    input  start, BallX, BallY, map_data,
    output map_addr, score, pellets_left, eat_pulse, level_clear, freeze, power_active
  );
endinterface

// File: rtl/pellet_tracker.sv
// Pellet bitmap, score and level sequencing for the pac-man playfield.
// Optional power pellets are enabled with the POWER_PELLET_EN macro.
module pellet_tracker #(
  parameter int unsigned GRID_COLS  = 28,
  parameter int unsigned GRID_ROWS  = 36,
  parameter int unsigned TILE_SHIFT = 3,
  parameter int unsigned X_ORIGIN   = 208,
  parameter int unsigned Y_ORIGIN   = 96,
  parameter int unsigned PELLET_PTS = 10
`ifdef POWER_PELLET_EN
  ,
  parameter int unsigned POWER_PTS    = 50,
  parameter int unsigned POWER_FRAMES = 360
`endif
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  pellet_tracker_if.slave  bus
);

  localparam int unsigned COL_W = $clog2(GRID_COLS);
  localparam int unsigned ROW_W = $clog2(GRID_ROWS);
  localparam int unsigned CNT_W = $clog2(GRID_ROWS + 1);
  localparam logic [9:0]  X0        = 10'(X_ORIGIN);
  localparam logic [9:0]  Y0        = 10'(Y_ORIGIN);
  localparam logic [9:0]  COLS_LIM  = 10'(GRID_COLS);
  localparam logic [9:0]  ROWS_LIM  = 10'(GRID_ROWS);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(GRID_ROWS);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, CLEAR} state_t;

  state_t                              state, state_nxt;
  logic [CNT_W-1:0]                    load_cnt;
  logic [ROW_W-1:0]                    load_row;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0] bitmap;
  logic [15:0]                         score;
  logic [9:0]                          pellets_left;
  logic                                eat_pulse, level_clear;

  logic [9:0]       dx, dy, col, row;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic             on_grid, pellet_here, eat;
  logic [15:0]      pts;
  logic [16:0]      score_sum;
  logic [15:0]      score_nxt;

  function automatic logic [9:0] popcount(input logic [GRID_COLS-1:0] v);
    logic [9:0] n;
    n = '0;
    for (int unsigned i = 0; i < GRID_COLS; i++) n = n + 10'(v[i]);
    return n;
  endfunction

  // Unsigned subtraction wraps below the origin, so the >= guards reject those positions
  // and the full-width compares reject columns/rows past the grid before truncation.
  assign dx          = bus.BallX - X0;
  assign dy          = bus.BallY - Y0;
  assign col         = dx >> TILE_SHIFT;
  assign row         = dy >> TILE_SHIFT;
  assign on_grid     = (bus.BallX >= X0) && (bus.BallY >= Y0) &&
                       (col < COLS_LIM) && (row < ROWS_LIM);
  assign col_idx     = col[COL_W-1:0];
  assign row_idx     = row[ROW_W-1:0];
  assign pellet_here = on_grid && bitmap[row_idx][col_idx];
  assign eat         = (state == PLAY) && !bus.start && pellet_here;
  assign load_row    = ROW_W'(load_cnt - 1'b1);

  assign score_sum = {1'b0, score} + {1'b0, pts};
  assign score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD:  if (bus.start) state_nxt = LOAD;
             else if (load_cnt == LOAD_LAST) state_nxt = PLAY;
      PLAY:  if (bus.start) state_nxt = LOAD;
             else if (pellets_left == '0 || (eat && pellets_left == 10'd1)) state_nxt = CLEAR;
      CLEAR: if (bus.start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ROM data lags the address by one cycle, so LOAD cycle k stores row k-1.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      load_cnt     <= '0;
      bitmap       <= '0;
      score        <= '0;
      pellets_left <= '0;
      eat_pulse    <= 1'b0;
      level_clear  <= 1'b0;
    end else begin
      eat_pulse   <= eat;
      level_clear <= eat && (pellets_left == 10'd1);
      if (bus.start) begin
        load_cnt     <= '0;
        pellets_left <= '0;
      end else if (state == LOAD) begin
        if (load_cnt != LOAD_LAST) load_cnt <= load_cnt + 1'b1;
        if (load_cnt != '0) begin
          bitmap[load_row] <= bus.map_data;
          pellets_left     <= pellets_left + popcount(bus.map_data);
        end
      end else if (eat) begin
        bitmap[row_idx][col_idx] <= 1'b0;
        pellets_left             <= pellets_left - 10'd1;
        score                    <= score_nxt;
      end
    end
  end

`ifdef POWER_PELLET_EN
  localparam int unsigned PWR_W = $clog2(POWER_FRAMES + 1);

  logic [PWR_W-1:0] power_cnt;
  logic             is_power;

  assign is_power = ((col_idx == COL_W'(1)) || (col_idx == COL_W'(GRID_COLS - 2))) &&
                    ((row_idx == ROW_W'(3)) || (row_idx == ROW_W'(26)));
  assign pts      = is_power ? 16'(POWER_PTS) : 16'(PELLET_PTS);

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n)                power_cnt <= '0;
    else if (bus.start)          power_cnt <= '0;
    else if (eat && is_power)    power_cnt <= PWR_W'(POWER_FRAMES);
    else if (power_cnt != '0)    power_cnt <= power_cnt - 1'b1;
  end

  assign bus.power_active = (power_cnt != '0);
`else
  assign pts              = 16'(PELLET_PTS);
  assign bus.power_active = 1'b0;
`endif

  assign bus.map_addr     = 6'(load_cnt);
  assign bus.score        = score;
  assign bus.pellets_left = pellets_left;
  assign bus.eat_pulse    = eat_pulse;
  assign bus.level_clear  = level_clear;
  assign bus.freeze       = (state != PLAY);

endmodule
